// File: rtl/tdm_label_fifo.sv
// tdm_label_fifo: bank of NCH circular FIFOs, each tagged with a runtime security level
// (0 = L, 1 = H). Output service is a free-running time-division slot counter, so the
// service timing seen by one channel never depends on another channel's occupancy.
// Downgrading H->L first scrubs (zeroes) every entry of the channel, one entry per cycle.
//
// Ports:
//   clk, reset          clock (rising edge), synchronous active-high reset
//   wr_en, wr_data      per-channel push request / data (channel c at [c*WIDTH +: WIDTH])
//   full                per-channel; pushes refused while high (full or scrubbing)
//   out_valid/data/ch   head entry of the channel owning the current slot
//   out_level           level of the current slot's channel
//   out_ready           consumer accept; pop on out_valid && out_ready
//   lvl_set/ch/val      level-change request
//   level, scrub_busy   per-channel level and scrub-in-progress flags
module tdm_label_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned NCH   = 2,
  localparam int unsigned CW   = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH-1:0]       wr_en,
  input  logic [NCH*WIDTH-1:0] wr_data,
  output logic [NCH-1:0]       full,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [CW-1:0]        out_ch,
  output logic                 out_level,
  input  logic                 out_ready,
  input  logic                 lvl_set,
  input  logic [CW-1:0]        lvl_ch,
  input  logic                 lvl_val,
  output logic [NCH-1:0]       level,
  output logic [NCH-1:0]       scrub_busy
);

  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CNTW = PW + 1;

  typedef enum logic [0:0] {StIdle, StScrub} state_e;

  logic [CW-1:0]    slot_q, slot_d;
  logic [WIDTH-1:0] mem_q [NCH][DEPTH];
  logic [WIDTH-1:0] mem_d [NCH][DEPTH];
  logic [PW-1:0]    rd_ptr_q [NCH];
  logic [PW-1:0]    rd_ptr_d [NCH];
  logic [PW-1:0]    wr_ptr_q [NCH];
  logic [PW-1:0]    wr_ptr_d [NCH];
  logic [CNTW-1:0]  count_q [NCH];
  logic [CNTW-1:0]  count_d [NCH];
  logic [PW-1:0]    scrub_idx_q [NCH];
  logic [PW-1:0]    scrub_idx_d [NCH];
  state_e           state_q [NCH];
  state_e           state_d [NCH];
  logic [NCH-1:0]   level_q, level_d;
  logic [NCH-1:0]   push, pop;

  // Outputs and per-channel handshakes, all from registered state.
  always_comb begin
    full       = '0;
    scrub_busy = '0;
    push       = '0;
    pop        = '0;
    for (int c = 0; c < NCH; c++) begin
      scrub_busy[c] = (state_q[c] == StScrub);
      full[c]       = (count_q[c] == CNTW'(DEPTH)) || scrub_busy[c];
      push[c]       = wr_en[c] && !full[c];
    end
    out_ch    = slot_q;
    out_valid = (count_q[slot_q] != '0) && (state_q[slot_q] == StIdle);
    out_data  = out_valid ? mem_q[slot_q][rd_ptr_q[slot_q]] : '0;
    out_level = level_q[slot_q];
    level     = level_q;
    pop[slot_q] = out_valid && out_ready;
  end

  always_comb begin
    slot_d      = (slot_q == CW'(NCH - 1)) ? '0 : slot_q + CW'(1);
    mem_d       = mem_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    scrub_idx_d = scrub_idx_q;
    state_d     = state_q;
    level_d     = level_q;
    for (int c = 0; c < NCH; c++) begin
      if (push[c]) begin
        mem_d[c][wr_ptr_q[c]] = wr_data[c*WIDTH +: WIDTH];
        wr_ptr_d[c]           = wr_ptr_q[c] + PW'(1);
      end
      if (pop[c]) begin
        rd_ptr_d[c] = rd_ptr_q[c] + PW'(1);
      end
      count_d[c] = count_q[c] + CNTW'(push[c]) - CNTW'(pop[c]);

      // Level transition is applied after the push/pop of the same cycle, so a
      // downgrade's pointer clear also discards a word pushed this cycle.
      unique case (state_q[c])
        StIdle: begin
          if (lvl_set && (lvl_ch == CW'(c)) && (lvl_val != level_q[c])) begin
            if (lvl_val) begin
              level_d[c] = 1'b1;
            end else begin
              state_d[c]     = StScrub;
              count_d[c]     = '0;
              rd_ptr_d[c]    = '0;
              wr_ptr_d[c]    = '0;
              scrub_idx_d[c] = '0;
            end
          end
        end
        StScrub: begin
          mem_d[c][scrub_idx_q[c]] = '0;
          scrub_idx_d[c]           = scrub_idx_q[c] + PW'(1);
          if (scrub_idx_q[c] == PW'(DEPTH - 1)) begin
            state_d[c] = StIdle;
            level_d[c] = 1'b0;
          end
        end
        default: state_d[c] = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q      <= '0;
      mem_q       <= '{default: '{default: '0}};
      rd_ptr_q    <= '{default: '0};
      wr_ptr_q    <= '{default: '0};
      count_q     <= '{default: '0};
      scrub_idx_q <= '{default: '0};
      state_q     <= '{default: StIdle};
      level_q     <= '0;
    end else begin
      slot_q      <= slot_d;
      mem_q       <= mem_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      scrub_idx_q <= scrub_idx_d;
      state_q     <= state_d;
      level_q     <= level_d;
    end
  end

endmodule

// File: tb/tb_tdm_label_fifo.sv
// Self-checking bench for tdm_label_fifo: directed scenarios followed by random traffic,
// checked every cycle against a queue-based reference model.
module tb_tdm_label_fifo;
  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int NCH   = 2;
  localparam int CW    = $clog2(NCH);

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NCH-1:0]       wr_en;
  logic [NCH*WIDTH-1:0] wr_data;
  logic [NCH-1:0]       full;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic [CW-1:0]        out_ch;
  logic                 out_level;
  logic                 out_ready;
  logic                 lvl_set;
  logic [CW-1:0]        lvl_ch;
  logic                 lvl_val;
  logic [NCH-1:0]       level;
  logic [NCH-1:0]       scrub_busy;

  always #5 clk = ~clk;

  tdm_label_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NCH(NCH)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch), .out_level(out_level),
    .out_ready(out_ready), .lvl_set(lvl_set), .lvl_ch(lvl_ch), .lvl_val(lvl_val),
    .level(level), .scrub_busy(scrub_busy)
  );

  // Reference model: one queue per channel, level, remaining scrub cycles, slot.
  logic [WIDTH-1:0] mq [NCH][$];
  int m_level [NCH];
  int m_scrub [NCH];
  int m_slot;
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      mq[c].delete();
      m_level[c] = 0;
      m_scrub[c] = 0;
    end
    m_slot = 0;
  endtask

  // Check outputs against the model, advance one clock, update the model.
  task automatic step();
    logic [NCH-1:0]   efull, elvl, ebusy;
    logic             ev;
    logic [WIDTH-1:0] ed;
    for (int c = 0; c < NCH; c++) begin
      efull[c] = (mq[c].size() == DEPTH) || (m_scrub[c] != 0);
      elvl[c]  = (m_level[c] != 0);
      ebusy[c] = (m_scrub[c] != 0);
    end
    ev = (mq[m_slot].size() != 0) && (m_scrub[m_slot] == 0);
    ed = ev ? mq[m_slot][0] : '0;
    chk("out_ch", 32'(out_ch), 32'(m_slot));
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("out_data", 32'(out_data), 32'(ed));
    chk("out_level", 32'(out_level), 32'(elvl[m_slot]));
    chk("full", 32'(full), 32'(efull));
    chk("level", 32'(level), 32'(elvl));
    chk("scrub_busy", 32'(scrub_busy), 32'(ebusy));
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      if (ev && out_ready) void'(mq[m_slot].pop_front());
      for (int c = 0; c < NCH; c++) begin
        if (wr_en[c] && !efull[c]) mq[c].push_back(wr_data[c*WIDTH +: WIDTH]);
      end
      for (int c = 0; c < NCH; c++) begin
        if (m_scrub[c] != 0) begin
          m_scrub[c]--;
          if (m_scrub[c] == 0) m_level[c] = 0;
        end else if (lvl_set && (int'(lvl_ch) == c) && (int'(lvl_val) != m_level[c])) begin
          if (lvl_val) begin
            m_level[c] = 1;
          end else begin
            mq[c].delete();
            m_scrub[c] = DEPTH;
          end
        end
      end
      m_slot = (m_slot + 1) % NCH;
    end
    @(negedge clk);
  endtask

  task automatic quiet();
    wr_en   = '0;
    lvl_set = 1'b0;
  endtask

  task automatic idle(input int n);
    quiet();
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push1(input int c, input logic [WIDTH-1:0] d);
    quiet();
    wr_en[c] = 1'b1;
    wr_data[c*WIDTH +: WIDTH] = d;
    step();
    wr_en = '0;
  endtask

  task automatic lvl(input int c, input logic v);
    quiet();
    lvl_set = 1'b1;
    lvl_ch  = CW'(c);
    lvl_val = v;
    step();
    lvl_set = 1'b0;
  endtask

  task automatic align(input int s);
    for (int i = 0; i < NCH && m_slot != s; i++) step();
  endtask

  initial begin
    reset = 1'b1; wr_en = '0; wr_data = '0; out_ready = 1'b0;
    lvl_set = 1'b0; lvl_ch = '0; lvl_val = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    reset = 1'b0;

    // Reset state and idle slot rotation.
    chk("rst_out_ch", 32'(out_ch), 0);
    chk("rst_full", 32'(full), 0);
    idle(8);

    // Fill ch0, overflow push dropped, then drain.
    for (int i = 1; i <= 4; i++) push1(0, WIDTH'(i));
    chk("ch0_full_after4", 32'(full[0]), 1);
    push1(0, 4'h5);
    out_ready = 1'b1;
    idle(10);

    // Lone ch1 word is served only in ch1 slots.
    push1(1, 4'hA);
    idle(4);

    // Full ch0: push+pop in ch0 slot, push dropped.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push1(0, WIDTH'(i + 6));
    align(0);
    out_ready = 1'b1;
    push1(0, 4'hF);
    out_ready = 1'b0;
    chk("ch0_not_full_after_pop", 32'(full[0]), 0);
    // Non-full push+pop keeps count.
    align(0);
    out_ready = 1'b1;
    push1(0, 4'hE);
    out_ready = 1'b0;
    chk("ch0_not_full_pushpop", 32'(full[0]), 0);
    out_ready = 1'b1;
    idle(10);

    // Upgrade ch1, push, downgrade with scrub; mid-scrub request ignored.
    out_ready = 1'b0;
    lvl(1, 1'b1);
    push1(1, 4'h3);
    push1(1, 4'h7);
    lvl(1, 1'b0);
    chk("scrub_busy1", 32'(scrub_busy[1]), 1);
    chk("scrub_level1", 32'(level[1]), 1);
    lvl(1, 1'b1);
    out_ready = 1'b1;
    idle(4);
    chk("post_scrub_level1", 32'(level[1]), 0);
    for (int i = 0; i < DEPTH; i++) chk("scrub_mem_zero", 32'(dut.mem_q[1][i]), 0);

    // Reset in the middle of a ch0 scrub.
    out_ready = 1'b0;
    lvl(0, 1'b1);
    push1(0, 4'h9);
    lvl(0, 1'b0);
    idle(1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("rst_scrub_busy", 32'(scrub_busy), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_slot", 32'(out_ch), 0);
    idle(2);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      wr_en     = NCH'($urandom);
      wr_data   = (NCH*WIDTH)'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      lvl_set   = ($urandom_range(0, 11) == 0);
      lvl_ch    = CW'($urandom);
      lvl_val   = 1'($urandom);
      reset     = ($urandom_range(0, 149) == 0);
      step();
    end
    reset = 1'b0;
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
